// File: rtl/uart_pkg.sv
// uart_pkg: baud-generator defaults and divisor config shared by the register block and Rx/Tx engines.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DIV_WIDTH  = 16;
  localparam int UART_FRAC_WIDTH = 4;

  typedef struct packed {
    logic [UART_DIV_WIDTH-1:0]  divisor;
    logic [UART_FRAC_WIDTH-1:0] frac;
  } baud_cfg_t;

endpackage

// File: rtl/uart_baud_frac_acc.sv
// uart_baud_frac_acc: fractional-divisor accumulator; carry requests one extra cycle on the next period.
// Latency: carry is combinational from acc+frac; acc advances on the reload edge.
// Backpressure: none. Only built with UART_BAUD_FRAC_EN defined.
`ifdef UART_BAUD_FRAC_EN
module uart_baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_WIDTH = UART_FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  step,
  input  logic [FRAC_WIDTH-1:0] frac,
  output logic                  carry
);

  logic [FRAC_WIDTH-1:0] acc;
  logic [FRAC_WIDTH:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[FRAC_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[FRAC_WIDTH-1:0];
    end
  end

endmodule
`endif

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable baud generator (rx oversample tick, tx bit tick, tx_clk); fractional divisor under UART_BAUD_FRAC_EN.
// Latency: first rx_tick D+1 cycles after enable or sync; all outputs registered.
// Backpressure: none; free-running strobes, divisor updates staged until the next reload/idle.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int                   OVERSAMPLE = UART_OVERSAMPLE,
  parameter int                   DIV_WIDTH  = UART_DIV_WIDTH,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET  = '0,
  parameter int                   FRAC_WIDTH = UART_FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync,
  input  logic                  div_load,
  input  logic [DIV_WIDTH-1:0]  divisor,
  input  logic [FRAC_WIDTH-1:0] frac,
  output logic                  rx_tick,
  output logic                  tx_tick,
  output logic                  tx_clk
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
`ifdef UART_BAUD_FRAC_EN
  // One spare bit so a carry period at the maximum divisor cannot wrap.
  localparam int CNT_W = DIV_WIDTH + 1;
`else
  localparam int CNT_W = DIV_WIDTH;
`endif

  logic [CNT_W-1:0]     div_cnt;
  logic [CNT_W-1:0]     cnt_load;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_stage;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [OS_W-1:0]      os_cnt;
  logic [OS_W-1:0]      os_nxt;
  logic                 pend;
  logic                 idle;
  logic                 cnt_zero;
  logic                 reload;
  logic                 copy;

  // The staged value is only ever swapped in at a period boundary, so a reload sees old or new, never a mix.
  assign idle     = !en || sync;
  assign cnt_zero = (div_cnt == '0);
  assign reload   = !idle && cnt_zero;
  assign copy     = pend && (idle || cnt_zero);
  assign div_eff  = copy ? div_stage : div_q;
  assign os_nxt   = os_cnt + 1'b1;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_WIDTH-1:0] frac_q;
  logic [FRAC_WIDTH-1:0] frac_stage;
  logic [FRAC_WIDTH-1:0] frac_eff;
  logic                  carry;

  assign frac_eff = copy ? frac_stage : frac_q;

  uart_baud_frac_acc #(
    .FRAC_WIDTH(FRAC_WIDTH)
  ) u_frac_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (idle),
    .step (reload),
    .frac (frac_eff),
    .carry(carry)
  );

  assign cnt_load = {1'b0, div_eff} + CNT_W'(carry && reload);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_stage <= '0;
      frac_q     <= '0;
    end else begin
      if (div_load) frac_stage <= frac;
      frac_q <= frac_eff;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^frac;
  assign cnt_load    = div_eff;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_stage <= DIV_RESET;
      div_q     <= DIV_RESET;
      pend      <= 1'b0;
      div_cnt   <= CNT_W'(DIV_RESET);
      os_cnt    <= '0;
      rx_tick   <= 1'b0;
      tx_tick   <= 1'b0;
      tx_clk    <= 1'b0;
    end else begin
      if (div_load) div_stage <= divisor;
      div_q <= div_eff;
      pend  <= div_load || (pend && !copy);
      if (idle) begin
        div_cnt <= cnt_load;
        os_cnt  <= '0;
        rx_tick <= 1'b0;
        tx_tick <= 1'b0;
        tx_clk  <= 1'b0;
      end else if (cnt_zero) begin
        div_cnt <= cnt_load;
        os_cnt  <= os_nxt;
        rx_tick <= 1'b1;
        tx_tick <= (os_cnt == OS_LAST);
        tx_clk  <= os_nxt[OS_W-1];
      end else begin
        div_cnt <= div_cnt - 1'b1;
        rx_tick <= 1'b0;
        tx_tick <= 1'b0;
      end
    end
  end

endmodule
